// File: rtl/async_fifo_read_streamer_pkg.sv
// Shared types and constants for the dual-clock FIFO read-side streamer.
package async_fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } rd_state_t;

    localparam int BUF_DEPTH         = 2;
    localparam int FLUSH_QUAL_CYCLES = 2;

endpackage

// File: rtl/async_fifo_read_streamer_skid_buffer.sv
// Two-entry registered skid buffer; push appears on m_data one cycle later.
// Holds m_data stable under backpressure; push is ignored when full, clear wins over everything.
module stream_skid_buffer
    import async_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              clear,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]    occ
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [OCC_W-1:0]      occ_q;
    logic                  push_ok;
    logic                  take;

    assign push_ok = push && (occ_q < OCC_W'(BUF_DEPTH));
    assign take    = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else if (clear) begin
            occ_q <= '0;
        end else begin
            case ({push_ok, take})
                2'b10: begin
                    if (occ_q == '0) begin
                        head_q <= data_in;
                    end else begin
                        tail_q <= data_in;
                    end
                    occ_q <= occ_q + 1'b1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 1'b1;
                end
                // push_ok excludes a full buffer, so simultaneous push/take only happens at occ=1
                2'b11:   head_q <= data_in;
                default: ;
            endcase
        end
    end

    assign m_valid = (occ_q != '0);
    assign m_data  = head_q;
    assign occ     = occ_q;

endmodule

// File: rtl/async_fifo_read_streamer.sv
// Read-domain FIFO consumer with framing, flush and beat counting; FIFO pop to m_data latency 1 cycle.
// Pops only while the skid buffer has room, so m_ready backpressure never loses or duplicates words.
module async_fifo_read_streamer
    import async_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_LEN   = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_almost_empty,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   flush_done,
    output logic [COUNT_WIDTH-1:0] words_out
);

    localparam int BEAT_W = $clog2(FRAME_LEN);
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int QUAL_W = $clog2(FLUSH_QUAL_CYCLES + 1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [QUAL_W-1:0] qual_cnt;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic              pop_ok;
    logic              empty_both;
    logic              handshake;
    logic              flush_hit;
    logic              buf_push;
    logic              buf_clear;

    assign pop_ok     = !fifo_empty && !fifo_almost_empty;
    assign empty_both = fifo_empty && fifo_almost_empty;
    assign handshake  = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush_hit = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = STREAM;
            end
            STREAM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    pop = pop_ok && (occ < OCC_W'(BUF_DEPTH));
                end
            end
            FLUSH: begin
                pop = pop_ok;
                if (empty_both && (qual_cnt == QUAL_W'(FLUSH_QUAL_CYCLES - 1))) begin
                    flush_hit = 1'b1;
                    state_nxt = enable ? STREAM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A new flush request overrides everything; outside FLUSH the word would only be discarded anyway
        if (flush) begin
            state_nxt = FLUSH;
            flush_hit = 1'b0;
            if (state != FLUSH) pop = 1'b0;
        end
    end

    assign fifo_rd_en = pop;
    assign buf_push   = pop && (state == STREAM);
    assign buf_clear  = flush || (state == FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            qual_cnt   <= '0;
            words_out  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= flush_hit;

            if (handshake) words_out <= words_out + 1'b1;

            if (flush) begin
                beat_cnt <= '0;
            end else if (handshake) begin
                if (beat_cnt == BEAT_W'(FRAME_LEN - 1)) beat_cnt <= '0;
                else                                    beat_cnt <= beat_cnt + 1'b1;
            end

            // Empty must hold across consecutive cycles to ride out write-pointer synchronizer lag
            if ((state != FLUSH) || flush || !empty_both) begin
                qual_cnt <= '0;
            end else if (qual_cnt != QUAL_W'(FLUSH_QUAL_CYCLES - 1)) begin
                qual_cnt <= qual_cnt + 1'b1;
            end
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (buf_push),
        .data_in (fifo_data),
        .clear   (buf_clear),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

    assign m_last = m_valid && (beat_cnt == BEAT_W'(FRAME_LEN - 1));
    assign busy   = (state == FLUSH) || (occ != '0);

endmodule

// File: tb/tb_async_fifo_read_streamer.sv
// Directed bench: behavioural FIFO read port feeding the streamer, scoreboard of accepted beats.
module tb_async_fifo_read_streamer;
    import async_fifo_rd_pkg::*;

    localparam int DW = 32;
    localparam int FL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          flush;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          flush_done;
    logic [CW-1:0] words_out;

    logic [DW-1:0] mem [0:63];
    logic [7:0]    wr_ptr;
    logic [7:0]    rd_ptr;
    logic          ae_force;

    int checks = 0;
    int errors = 0;
    int pop_seen = 0;
    int fd_cnt = 0;
    int rx_cnt = 0;
    logic [DW-1:0] rx_data [0:127];
    logic          rx_last [0:127];

    int base_pop;
    int base_rx;
    int base_fd;
    logic [9:0] lv;

    always #5 clk = ~clk;

    async_fifo_read_streamer #(
        .DATA_WIDTH  (DW),
        .FRAME_LEN   (FL),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .flush             (flush),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .m_data            (m_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_last            (m_last),
        .busy              (busy),
        .flush_done        (flush_done),
        .words_out         (words_out)
    );

    assign fifo_data         = mem[rd_ptr[5:0]];
    assign fifo_empty        = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = fifo_empty || ae_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        rd_ptr <= 8'd0;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
    end

    // Inputs only change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            rx_data[rx_cnt] = m_data;
            rx_last[rx_cnt] = m_last;
            rx_cnt++;
        end
        if (fifo_rd_en) pop_seen++;
        if (flush_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!m_valid && k < 20) begin
            step(1);
            k++;
        end
        chk(tag, m_valid, 1);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        flush    = 1'b0;
        m_ready  = 1'b1;
        ae_force = 1'b0;
        wr_ptr   = 8'd0;
        step(2);

        // Test 1: reset values, then three words stream out back to back
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_words_out", words_out, 0);
        base_pop = pop_seen;
        reset_n = 1'b1;
        wait_valid("t1_valid");
        chk("t1_d0", m_data, 32'hA1);
        step(1);
        chk("t1_d1", m_data, 32'hA2);
        step(1);
        chk("t1_d2", m_data, 32'hA3);
        step(1);
        chk("t1_valid_drop", m_valid, 0);
        chk("t1_words_out", words_out, 3);
        chk("t1_pops", pop_seen - base_pop, 3);

        // Test 2: backpressure fills the buffer with exactly two words
        m_ready  = 1'b0;
        base_pop = pop_seen;
        base_rx  = rx_cnt;
        for (int i = 1; i <= 5; i++) push_word(32'hB0 + i);
        step(6);
        chk("t2_pops_held", pop_seen - base_pop, 2);
        chk("t2_valid_held", m_valid, 1);
        chk("t2_data_held", m_data, 32'hB1);
        m_ready = 1'b1;
        step(8);
        chk("t2_rx_count", rx_cnt - base_rx, 5);
        for (int i = 0; i < 5; i++) chk("t2_rx_order", rx_data[base_rx + i], 32'hB1 + i);
        chk("t2_words_out", words_out, 8);

        // Test 3: framing over ten beats with FRAME_LEN=4
        reset_n = 1'b0;
        wr_ptr  = 8'd0;
        step(1);
        for (int i = 0; i < 10; i++) push_word(32'hC0 + i);
        reset_n = 1'b1;
        base_rx = rx_cnt;
        step(16);
        chk("t3_rx_count", rx_cnt - base_rx, 10);
        for (int i = 0; i < 10; i++) lv[i] = rx_last[base_rx + i];
        chk("t3_last_pattern", lv, 10'h088);
        chk("t3_last_data", rx_data[base_rx + 9], 32'hC9);
        chk("t3_beat_cnt", dut.beat_cnt, 2);
        chk("t3_words_out", words_out, 4'hA);

        // Test 4: flush with a full buffer and six words still in the FIFO
        m_ready  = 1'b0;
        base_pop = pop_seen;
        for (int i = 0; i < 8; i++) push_word(32'hD0 + i);
        step(4);
        chk("t4_prefill_pops", pop_seen - base_pop, 2);
        chk("t4_busy_full", busy, 1);
        base_pop = pop_seen;
        base_fd  = fd_cnt;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("t4_valid_cleared", m_valid, 0);
        chk("t4_busy_flush", busy, 1);
        chk("t4_words_kept", words_out, 4'hA);
        step(7);
        chk("t4_discard_pops", pop_seen - base_pop, 6);
        chk("t4_done_early", flush_done, 0);
        step(1);
        chk("t4_done_pulse", flush_done, 1);
        chk("t4_state_stream", dut.state, STREAM);
        step(1);
        chk("t4_done_single", flush_done, 0);
        chk("t4_done_count", fd_cnt - base_fd, 1);
        m_ready = 1'b1;
        base_rx = rx_cnt;
        for (int i = 0; i < 7; i++) push_word(32'hE0 + i);
        step(1);
        chk("t4_post_valid", m_valid, 1);
        chk("t4_post_data", m_data, 32'hE0);
        chk("t4_post_beat", dut.beat_cnt, 0);
        step(7);
        chk("t4_post_count", rx_cnt - base_rx, 7);
        chk("t4_post_last_beat3", rx_last[base_rx + 3], 1);
        chk("t4_post_tail", rx_data[base_rx + 6], 32'hE6);
        chk("t4_words_wrap", words_out, 4'h1);

        // Test 5: asynchronous reset between clock edges
        m_ready = 1'b0;
        push_word(32'hF0);
        push_word(32'hF1);
        step(3);
        chk("t5_pre_valid", m_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", m_valid, 0);
        chk("t5_async_data", m_data, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_words", words_out, 0);
        chk("t5_async_last", m_last, 0);
        wr_ptr = 8'd0;
        step(1);

        // Test 6: disable with two words buffered and more waiting in the FIFO
        for (int i = 0; i < 4; i++) push_word(32'h60 + i);
        reset_n  = 1'b1;
        base_pop = pop_seen;
        step(5);
        chk("t6_prefill_pops", pop_seen - base_pop, 2);
        chk("t6_head", m_data, 32'h60);
        enable   = 1'b0;
        m_ready  = 1'b1;
        base_pop = pop_seen;
        base_rx  = rx_cnt;
        step(1);
        chk("t6_state_idle", dut.state, IDLE);
        chk("t6_drain_d1", m_data, 32'h61);
        chk("t6_busy_draining", busy, 1);
        step(1);
        chk("t6_valid_off", m_valid, 0);
        chk("t6_busy_off", busy, 0);
        chk("t6_rd_en_idle", fifo_rd_en, 0);
        chk("t6_no_pops", pop_seen - base_pop, 0);
        chk("t6_rx_count", rx_cnt - base_rx, 2);
        chk("t6_rx_d0", rx_data[base_rx], 32'h60);
        chk("t6_rx_d1", rx_data[base_rx + 1], 32'h61);

        // Almost-empty alone must block pops even with data present
        ae_force = 1'b1;
        enable   = 1'b1;
        step(2);
        chk("ae_state_stream", dut.state, STREAM);
        chk("ae_alone_no_pop", fifo_rd_en, 0);
        ae_force = 1'b0;
        #1;
        chk("ae_clear_pop", fifo_rd_en, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_read_streamer.md
Name: async_fifo_read_streamer

Overview:
Read-side consumer for the dual-clock FIFO, running in the read clock domain. It pops words from the FIFO read port, whose read data is combinational from the current read pointer, and presents them on a registered valid/ready stream with full 1-word/cycle throughput. It adds frame delimiting (m_last), a flush mode that discards FIFO contents, and a delivered-word counter.

Parameters:
DATA_WIDTH, 32, width of FIFO words and m_data
FRAME_LEN, 8, beats per frame; m_last on the final beat; legal range 2 to 65535
COUNT_WIDTH, 16, width of words_out counter

Ports:
clk  in  1  read-domain clock; same clock as the FIFO rd_clk
reset_n  in  1  asynchronous, active-low reset
enable  in  1  allow pops from the FIFO
flush  in  1  one-cycle request to discard buffered and FIFO data
fifo_data  in  DATA_WIDTH  FIFO data_out, valid combinationally for the current read pointer
fifo_empty  in  1  FIFO registered empty flag
fifo_almost_empty  in  1  FIFO early empty flag
fifo_rd_en  out  1  pop strobe to the FIFO rd_en
m_data  out  DATA_WIDTH  output stream data
m_valid  out  1  output data valid
m_ready  in  1  downstream ready
m_last  out  1  final beat of a frame, qualified by m_valid
busy  out  1  high in FLUSH, or when the buffer is non-empty
flush_done  out  1  one-cycle pulse when a flush completes
words_out  out  COUNT_WIDTH  count of accepted beats (m_valid and m_ready); wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (reset_n low, asynchronous):
  - m_valid=0, m_data=0, m_last=0, fifo_rd_en=0, busy=0, flush_done=0, words_out=0.
  - state=IDLE, occupancy=0, beat_cnt=0.
- pop_ok = !fifo_empty && !fifo_almost_empty. Both flags must be low; a pop is never issued on either flag alone.
- fifo_rd_en is combinational:
  - STREAM: pop_ok && occ<2.
  - FLUSH: pop_ok.
  - IDLE: 0.
- Buffer:
  - Two-entry skid buffer, occ in 0..2.
  - On a pop in STREAM, fifo_data is captured the same cycle and appears on m_data at the next edge (latency 1).
  - occ_next = occ + pop - (m_valid && m_ready). occ never exceeds 2 and never underflows.
  - Sustained 1 beat/cycle while m_ready=1 and the FIFO is non-empty.
  - m_valid = (occ!=0). m_data is the oldest entry and is held stable while m_valid && !m_ready.
- beat_cnt:
  - Increments on each handshake and wraps to 0 after FRAME_LEN-1.
  - m_last = m_valid && (beat_cnt==FRAME_LEN-1).
  - words_out increments on each handshake.
- State machine:
  - IDLE: no pops, but the buffer still drains to downstream. Go to STREAM when enable=1.
  - STREAM: normal operation. Go to IDLE when enable=0; a pop in the transition cycle is not issued.
  - Any state with flush=1: go to FLUSH.
  - FLUSH:
    - On entry, buffer cleared (occ=0, m_valid=0) and beat_cnt=0; pops every cycle while pop_ok, data discarded.
    - When fifo_empty && fifo_almost_empty have both been high for 2 consecutive cycles (this covers synchronizer lag), pulse flush_done for one cycle and go to enable ? STREAM : IDLE.
    - flush asserted while already in FLUSH restarts the 2-cycle empty qualification.
- Simultaneous flush and handshake in the same cycle: the handshake counts in words_out, then the buffer clears.
- Simultaneous pop and handshake at occ=2: not possible, because no pop is issued at occ=2.
- words_out wraps from all-ones to 0 with no sticky flag.

Decomposition:
- Package async_fifo_rd_pkg:
  - state enum rd_state_t {IDLE, STREAM, FLUSH}.
  - Localparam BUF_DEPTH=2.
  - Localparam FLUSH_QUAL_CYCLES=2.
- Sub-module stream_skid_buffer (DATA_WIDTH parameter): 2-entry register buffer with push, data_in, clear, m_valid/m_ready/m_data and an occ output. The top level holds the FSM, pop logic and counters.

Test Plan:
1. Reset with the FIFO holding 3 words (0xA1, 0xA2, 0xA3), enable=1, m_ready=1 -> after reset release, m_data shows 0xA1, 0xA2, 0xA3 on consecutive cycles, m_valid drops after 0xA3, words_out=3, fifo_rd_en pulsed exactly 3 times.
2. Backpressure: 5 words, m_ready=0 for 6 cycles -> exactly 2 pops (occ=2), m_data=first word held stable; after m_ready=1, all 5 are delivered in order with no loss or duplication.
3. Framing with FRAME_LEN=4: 10 words streamed -> m_last on beats 4 and 8 only; beat_cnt=2 at the end, words_out=10.
4. Flush mid-stream: with occ=2 and 6 words left in the FIFO, pulse flush -> m_valid=0 next cycle, 6 discard pops, flush_done pulses once 2 cycles after both empty flags are high, state returns to STREAM, and the next written word is delivered with beat_cnt=0.
5. Async reset mid-frame (reset_n low between edges while m_valid=1) -> all outputs go to their reset values immediately, without waiting for a clock edge.
6. enable=0 with 2 words buffered and the FIFO non-empty -> the buffered words still drain, fifo_rd_en stays 0, busy falls once occ=0.
